// File: rtl/mem_dump_tx_pkg.sv
// Shared types and constants for the memory dump transmitter.
// Holds the FSM state enum, frame/memory sizes and the default bit time.
package mem_dump_tx_pkg;

    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int FRAME_LEN        = 18;
    localparam int MEM_DEPTH        = 16;
    localparam int ADDR_W           = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HDR,
        FETCH,
        WAIT_RD,
        SEND,
        SEND_SUM,
        FINISH
    } state_t;

endpackage

// File: rtl/mem_dump_tx_if.sv
// Signal bundle around mem_dump_tx: dump request, memory read bus and
// serial/status outputs. master = transmitter side, slave = system side.
interface mem_dump_tx_if;
    import mem_dump_tx_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              txd;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_data,
        output mem_addr, txd, busy, done
    );

    modport slave (
        output start, mem_data,
        input  mem_addr, txd, busy, done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// Ports: clk, rst (sync, active-high), load/data in, ready/txd out.
module uart_tx_byte
    import mem_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic          active_q, active_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        active_d = active_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        if (!active_q) begin
            if (load) begin
                active_d = 1'b1;
                shift_d  = {1'b1, data, 1'b0};
                bit_d    = 4'd0;
                cnt_d    = '0;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            // Shift in ones so the line rests high after the stop bit.
            shift_d = {1'b1, shift_q[9:1]};
            if (bit_q == 4'd9) begin
                active_d = 1'b0;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            shift_q  <= '1;
            bit_q    <= 4'd0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready = !active_q;
    assign txd   = active_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/mem_dump_tx.sv
// Dumps 16 memory bytes over UART as HEADER, data[0..15], CHECKSUM.
// Ports: CLOCK_50, rst, start, mem_addr/mem_data, UART_TXD, busy, done.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              UART_TXD,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        data_q, data_d;
    logic              have_q, have_d;
    logic              sum_sent_q, sum_sent_d;

    logic       ser_load;
    logic [7:0] ser_data;
    logic       ser_ready;
    logic       ser_txd;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = LOAD_HDR;
            LOAD_HDR: state_d = FETCH;
            FETCH:    state_d = WAIT_RD;
            WAIT_RD:  if (have_q && ser_ready) state_d = SEND;
            SEND:     state_d = (addr_q != LAST_ADDR) ? FETCH : SEND_SUM;
            SEND_SUM: if (sum_sent_q && ser_ready) state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // The header is loaded straight from IDLE so its start bit appears
    // on the same edge that raises busy.
    always_comb begin
        ser_load = 1'b0;
        ser_data = data_q;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy     = 1'b0;
                ser_load = start;
                ser_data = HEADER;
            end
            WAIT_RD:  ser_load = have_q && ser_ready;
            SEND_SUM: begin
                ser_load = !sum_sent_q && ser_ready;
                ser_data = sum_q;
            end
            FINISH: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Data is captured once on the first WAIT_RD cycle; later changes
    // on mem_data cannot alter the byte or the checksum.
    always_comb begin
        addr_d     = addr_q;
        sum_d      = sum_q;
        data_d     = data_q;
        have_d     = have_q;
        sum_sent_d = sum_sent_q;
        unique case (state_q)
            IDLE: begin
                addr_d     = '0;
                sum_d      = '0;
                have_d     = 1'b0;
                sum_sent_d = 1'b0;
            end
            FETCH: have_d = 1'b0;
            WAIT_RD: begin
                if (!have_q) begin
                    data_d = mem_data;
                    sum_d  = sum_q + mem_data;
                    have_d = 1'b1;
                end
            end
            SEND: begin
                if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
            end
            SEND_SUM: begin
                if (ser_ready && !sum_sent_q) sum_sent_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            addr_q     <= '0;
            sum_q      <= '0;
            data_q     <= '0;
            have_q     <= 1'b0;
            sum_sent_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            sum_q      <= sum_d;
            data_q     <= data_d;
            have_q     <= have_d;
            sum_sent_q <= sum_sent_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk   (CLOCK_50),
        .rst   (rst),
        .load  (ser_load),
        .data  (ser_data),
        .ready (ser_ready),
        .txd   (ser_txd)
    );

    assign mem_addr = addr_q;
    assign UART_TXD = ser_txd;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Scoreboard bench for mem_dump_tx: expected frames are queued at start,
// a UART decoder on the serial line pops and compares each byte.
module tb_mem_dump_tx;

    localparam int CPB  = 4;
    localparam int BITS = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_dump_tx_if bus();

    mem_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .HEADER(8'hA5)
    ) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .start    (bus.start),
        .mem_addr (bus.mem_addr),
        .mem_data (bus.mem_data),
        .UART_TXD (bus.txd),
        .busy     (bus.busy),
        .done     (bus.done)
    );

    logic [7:0] mem [16];
    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] exp_q[$];

    // Reference frame: header, the 16 bytes, their sum mod 256.
    task automatic push_frame();
        int s;
        s = 0;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(mem[i]);
            s = s + int'(mem[i]);
        end
        exp_q.push_back(8'(s % 256));
    endtask

    int         rx_cnt    = -1;
    int         rx_idx    = 0;
    int         gap       = 0;
    int         done_cnt  = 0;
    int         cyc       = 0;
    int         last_done = -100;
    logic [9:0] rx_bits;
    logic       glitch;
    logic [7:0] e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rx_cnt = -1;
            rx_idx = 0;
            gap    = 0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                chk("done_busy_excl", bus.busy, 0);
                chk("done_frame_len", rx_idx, 0);
                chk("done_addr_15", bus.mem_addr, 15);
                last_done = cyc;
            end
            if (rx_cnt < 0) begin
                if (bus.txd === 1'b0) begin
                    if (rx_idx == 0)
                        chk("idle_after_done", (cyc - last_done) >= 2, 1);
                    else
                        chk("byte_gap_le4", gap <= 4, 1);
                    chk("busy_in_frame", bus.busy, 1);
                    rx_bits    = '1;
                    rx_bits[0] = 1'b0;
                    glitch     = 1'b0;
                    rx_cnt     = 1;
                end else begin
                    gap++;
                end
            end else begin
                if (rx_cnt % CPB == 0) rx_bits[rx_cnt / CPB] = bus.txd;
                else if (bus.txd !== rx_bits[rx_cnt / CPB]) glitch = 1'b1;
                rx_cnt++;
                if (rx_cnt == BITS) begin
                    chk("bit_width", glitch, 0);
                    chk("stop_bit", rx_bits[9], 1);
                    chk("byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d", rx_idx), rx_bits[8:1], e);
                    end
                    rx_idx = (rx_idx == 17) ? 0 : rx_idx + 1;
                    rx_cnt = -1;
                    gap    = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame();
        push_frame();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_txd_low", bus.txd, 0);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_cnt < target; i++) tick(1);
        chk("frame_done", done_cnt, target);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_byte(input int idx);
        int k;
        k = 0;
        while (k < 3000 && !(rx_idx == idx && rx_cnt > 2 * CPB
                             && rx_cnt < 8 * CPB)) begin
            tick(1);
            k++;
        end
        chk($sformatf("reach_byte%0d", idx), rx_idx, idx);
    endtask

    int base;
    int k;

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        rst = 1'b1;
        tick(3);
        chk("rst_txd", bus.txd, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_addr", bus.mem_addr, 0);
        rst = 1'b0;
        tick(2);

        // Incrementing pattern: checksum 0x78.
        run_frame();
        wait_done(1);
        tick(1);
        chk("busy_low_after", bus.busy, 0);

        // All ones: checksum 0xF0.
        for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
        run_frame();
        wait_done(2);

        // A start while busy is neither honoured nor queued.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        run_frame();
        wait_byte(5);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_done(3);
        tick(300);
        chk("no_second_frame", done_cnt, 3);
        chk("idle_after_ignored", bus.busy, 0);

        // Reset inside byte 9 aborts the frame without done.
        run_frame();
        wait_byte(9);
        rst = 1'b1;
        tick(1);
        chk("abort_txd", bus.txd, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(100);
        chk("abort_no_done", done_cnt, 3);
        run_frame();
        wait_done(4);

        // start held high: three back-to-back frames, then released.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        base = done_cnt;
        push_frame();
        push_frame();
        push_frame();
        bus.start = 1'b1;
        k = 0;
        while (k < 9000 && done_cnt < base + 3) begin
            tick(1);
            k++;
        end
        bus.start = 1'b0;
        chk("held_frames", done_cnt, base + 3);
        tick(300);
        chk("held_stop", done_cnt, base + 3);
        chk("held_drained", exp_q.size(), 0);

        // Memory rewritten after address 3 has been captured.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        base = done_cnt;
        run_frame();
        k = 0;
        while (k < 3000 && bus.mem_addr != 4'd4) begin
            tick(1);
            k++;
        end
        chk("reach_addr4", bus.mem_addr, 4);
        mem[3] = ~mem[3];
        mem[2] = mem[2] + 8'd1;
        wait_done(base + 1);

        // Random contents with random idle spacing.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            tick($urandom_range(0, 20));
            base = done_cnt;
            run_frame();
            wait_done(base + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_dump_tx.md
MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clocks per UART bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter HEADER, default 8'hA5, giving the frame start byte.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a dump request, sampled on each clock.
REQ-006 The block SHALL have port mem_addr, output, 4 bits: registered memory read address.
REQ-007 The block SHALL have port mem_data, input, 8 bits: memory read data, valid one clock after mem_addr changes.
REQ-008 The block SHALL have port UART_TXD, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-clock pulse at frame end.

Function
REQ-011 The frame SHALL be 18 bytes in order: HEADER, mem[0]..mem[15], then CHECKSUM.
REQ-012 CHECKSUM SHALL be the 8-bit sum of the 16 data bytes modulo 256; HEADER is excluded.
REQ-013 Each byte SHALL be sent as 8N1: start bit 0, data bits LSB first, stop bit 1.
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT clocks.
REQ-015 When start is high and busy is low, the block SHALL raise busy and drive UART_TXD low (HEADER start bit) on the next edge.
REQ-016 A start pulse while busy is high SHALL be ignored and SHALL NOT be queued.
REQ-017 The gap between the end of one stop bit and the next start bit SHALL be 0 to 4 clocks, with UART_TXD high throughout the gap.
REQ-018 The block SHALL prefetch the next data byte while the current byte shifts out.
REQ-019 mem_addr SHALL increment from 0 to 15 and SHALL NOT wrap within a frame.
REQ-020 The FSM SHALL have the states IDLE, LOAD_HDR, FETCH, WAIT_RD, SEND, SEND_SUM and FINISH.
REQ-021 IDLE SHALL go to LOAD_HDR on an accepted start.
REQ-022 LOAD_HDR SHALL go to FETCH.
REQ-023 FETCH SHALL go to WAIT_RD, which latches mem_data and adds it to the checksum.
REQ-024 WAIT_RD SHALL go to SEND when the serializer is ready.
REQ-025 SEND SHALL go to FETCH while mem_addr is below 15, and to SEND_SUM after address 15.
REQ-026 SEND_SUM SHALL go to FINISH after the checksum stop bit.
REQ-027 FINISH SHALL pulse done, drop busy, and return to IDLE.
REQ-028 busy and done SHALL both fall on the same edge; done SHALL never be high while busy is high.
REQ-029 A start in the same cycle done is high SHALL be ignored; the next accepted start is the following cycle.
REQ-030 mem_data SHALL be captured exactly once per address; values changing after capture SHALL NOT affect the frame.

Reset
REQ-031 While rst is high, the block SHALL force UART_TXD=1, busy=0, done=0, mem_addr=0, checksum=0, state=IDLE and the bit counter to 0 on each edge.
REQ-032 A reset asserted mid-byte SHALL abort the frame, return UART_TXD high on the next edge, and produce no done pulse.
REQ-033 rst SHALL take priority over start in the same cycle.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration, the frame length constant (18), the memory depth constant (16) and the default CLKS_PER_BIT.
REQ-035 The bit serializer SHALL be one sub-module, uart_tx_byte, with inputs load and data[7:0], outputs ready and txd, and parameter CLKS_PER_BIT.
REQ-036 The remaining logic (FSM, address counter, checksum) SHALL be in mem_dump_tx.

Verification (CLKS_PER_BIT=4, memory model with 1-clock read latency)
REQ-037 Memory mem[i]=i (0..15), pulse start -> decoded bytes A5,00,01,..,0F,78; done pulses once; busy high for the whole frame.
REQ-038 Memory all FF -> checksum byte F0 (16x255 mod 256); each bit exactly 4 clocks wide.
REQ-039 start pulsed again during byte 5 -> frame unchanged; no second frame; done pulses once.
REQ-040 rst asserted during the data bits of byte 9 -> UART_TXD=1 next clock, busy=0, no done; then a new start -> full correct 18-byte frame.
REQ-041 start held high continuously -> back-to-back frames, each 18 bytes, with at least one idle clock between done and the next start bit.
REQ-042 Memory changed after address 3 is fetched -> byte 3 keeps its old value and the checksum matches the transmitted bytes.
